// File: rtl/register_file_param.sv
// Parametrised 2-read/1-write register file with a sequential clear engine.
// Optional macro RF_BYPASS_EN forwards same-edge write data to the read ports.
module register_file_param #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                ZERO_REG  = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic              clr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              ready,
    input  logic [ADDR_W-1:0] dbg_reg,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;
    logic              wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The clear walks every entry once; the last entry is the all-ones count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_CLEAR: begin
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == '1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready = (state == ST_IDLE);
    assign wr_en = (state == ST_IDLE) && reg_write && !(ZERO_EN && (write_reg == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= RESET_VAL;
            end else if (wr_en) begin
                mem[write_reg] <= write_data;
            end
        end
    end

    // Zero-register masking is applied last so it also overrides forwarded data.
    always_comb begin
        rd1_val  = mem[read_reg1];
        rd2_val  = mem[read_reg2];
        dbg_data = mem[dbg_reg];
`ifdef RF_BYPASS_EN
        if (wr_en && (write_reg == read_reg1)) begin
            rd1_val = write_data;
        end
        if (wr_en && (write_reg == read_reg2)) begin
            rd2_val = write_data;
        end
`endif
        if (ZERO_EN && (read_reg1 == '0)) begin
            rd1_val = '0;
        end
        if (ZERO_EN && (read_reg2 == '0)) begin
            rd2_val = '0;
        end
        if (ZERO_EN && (dbg_reg == '0)) begin
            dbg_data = '0;
        end
    end

    // Read ports stay at zero for the whole time the clear engine owns the array.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_CLEAR) || clr) begin
            read_data1 <= '0;
            read_data2 <= '0;
        end else begin
            read_data1 <= rd1_val;
            read_data2 <= rd2_val;
        end
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the single-cycle datapath register file.
- Configurable data width and depth; two registered read ports and one write port.
- Optional hardwired-zero entry 0.
- Sequential clear engine: initialises every entry after reset or on request, and reports when the file is usable.
- Sits between decode (register addresses) and ALU/writeback in the MIPS datapath.

Parameters:
DATA_W, 32, width of each register entry in bits
ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W (local, derived)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register
RESET_VAL, 0, value (DATA_W bits) loaded into every entry by the clear engine

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
read_reg1  input  ADDR_W  read port 1 address
read_reg2  input  ADDR_W  read port 2 address
write_reg  input  ADDR_W  write address
write_data  input  DATA_W  write data
reg_write  input  1  write enable
clr  input  1  synchronous request to re-clear all entries (pulse)
read_data1  output  DATA_W  registered read data, port 1
read_data2  output  DATA_W  registered read data, port 2
ready  output  1  1 = clear complete, reads/writes honoured
dbg_reg  input  ADDR_W  debug peek address
dbg_data  output  DATA_W  combinational contents of entry dbg_reg (ZERO_REG rule applies)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - State goes to CLEAR; clear counter = 0.
  - ready = 0; read_data1 = read_data2 = 0.
  - rst takes priority over every other input, including mid-CLEAR; the counter restarts from 0.
- States:
  - CLEAR: each cycle writes RESET_VAL to entry[cnt] and increments cnt. After the cycle that writes entry DEPTH-1, state goes to IDLE. ready rises on the following edge, so CLEAR lasts exactly DEPTH cycles after rst deasserts.
  - IDLE: ready = 1, normal operation.
  - clr=1 in IDLE: enters CLEAR next edge with cnt = 0 and ready = 0. Any write presented in that same cycle is still performed, then overwritten by the clear. clr in CLEAR is ignored.
- In CLEAR:
  - reg_write is ignored.
  - read_data1/2 hold 0.
- Reads (IDLE):
  - read_data1 <= entry[read_reg1] and read_data2 <= entry[read_reg2] on every edge. Latency is 1 cycle; no enable.
  - Both ports may address the same entry.
- Writes (IDLE):
  - If reg_write = 1, entry[write_reg] <= write_data at the edge.
  - If ZERO_REG = 1 and write_reg = 0, the write is dropped.
- Zero register:
  - ZERO_REG = 1: any read of address 0 (ports 1, 2, dbg) returns 0 regardless of storage contents.
  - ZERO_REG = 0: entry 0 behaves like any other register.
- Read-during-write, same address, same edge:
  - Without bypass, read_data returns the OLD contents (read-before-write).
  - With bypass, see Optional Feature.
- Widths: write_data is stored unmodified. No sign extension or truncation inside the block.
- dbg_data: purely combinational from storage. Returns RESET_VAL for entries already cleared during CLEAR and old contents for entries not yet reached.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when reg_write = 1, state IDLE, and write_reg == read_regN (and not (ZERO_REG = 1 and address 0)), read_data<N> <= write_data at that edge; the new value is visible with the same 1-cycle latency. Storage is updated as normal.
- Not defined: read-before-write, so read_data returns the previous contents. No forwarding logic is generated.

Test Plan:
- Reset/clear timing, defaults: pulse rst 1 cycle, then release.
  - ready = 0 for exactly 32 cycles, then 1.
  - read_data1/2 = 0 throughout.
  - dbg_data for all 32 entries = 0.
- Basic write/read, after ready:
  - Write 0xDEADBEEF to r5, then 0x12345678 to r31.
  - Next cycle read_reg1 = 5, read_reg2 = 31 -> one edge later, read_data1 = 0xDEADBEEF, read_data2 = 0x12345678.
- Zero register:
  - ZERO_REG = 1: write 0xFFFFFFFF to r0, read r0 on both ports -> 0, dbg_data(0) = 0.
  - ZERO_REG = 0 build: same sequence -> 0xFFFFFFFF.
- Read-during-write:
  - r7 = 0x11; same edge write r7 = 0x22 with read_reg1 = 7.
  - Without RF_BYPASS_EN: read_data1 = 0x11, and 0x22 on the next read.
  - With RF_BYPASS_EN: read_data1 = 0x22 immediately.
- Clear request and writes during CLEAR:
  - r3 = 0xA5, RESET_VAL = 0x5A5A5A5A, then pulse clr.
  - ready drops next edge.
  - reg_write to r3 = 0x77 during CLEAR is ignored.
  - After 32 cycles ready = 1 and r3 reads 0x5A5A5A5A.
- Reset mid-clear:
  - Assert rst at cycle 10 of CLEAR.
  - The counter restarts; ready stays 0 for a full 32 cycles after rst release.
  - Parametric run with DATA_W = 16, ADDR_W = 3 -> CLEAR lasts 8 cycles.
